// File: rtl/sensor_conditioner_pkg.sv
// rtl/sensor_conditioner_pkg.sv - shared types for the sensor conditioner
// Purpose : humo debounce FSM state encoding and a settled-state helper.
// Ports   : none (package).
package sensor_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_LO      = 2'b00,
      ST_WAIT_HI = 2'b01,
      ST_HI      = 2'b10,
      ST_WAIT_LO = 2'b11
   } humo_state_e;

   // The humo path is settled when it is not qualifying a new level.
   function automatic logic is_settled(input humo_state_e s);
      return (s == ST_LO) || (s == ST_HI);
   endfunction

endpackage

// File: rtl/sensor_conditioner_sync_2ff.sv
// rtl/sensor_conditioner_sync_2ff.sv - W-bit two-flop synchroniser
// Purpose : bring an asynchronous bus into the clk domain (bits may skew by one cycle).
// Ports   : clk, rst_n (async active-low), d_i [W] raw input, q_o [W] synchronised output.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronise and debounce smoke flag and current code
// Purpose : clean humo/corriente levels plus one-cycle change pulses for the alarm FSM.
// Ports   : clk, reset (async active-low), humo_in, current_in [N] (raw, async);
//           humo, corriente [N] (debounced), humo_rise, corr_chg (1-cycle pulses),
//           stable (no debouncer mid-qualification).
module sensor_conditioner
   import sensor_conditioner_pkg::*;
#(
   parameter int N         = 3,
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         humo_in,
   input  logic [N-1:0] current_in,
   output logic         humo,
   output logic [N-1:0] corriente,
   output logic         humo_rise,
   output logic         corr_chg,
   output logic         stable
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic         hs;
   logic [N-1:0] cs;

   sync_2ff #(.W(1)) u_sync_humo (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (humo_in),
      .q_o   (hs)
   );

   sync_2ff #(.W(N)) u_sync_curr (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (current_in),
      .q_o   (cs)
   );

   humo_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             humo_q, humo_d;
   logic             humo_rise_q, humo_rise_d;
   logic [N-1:0]     cand_q, cand_d;
   logic [CNT_W-1:0] ccnt_q, ccnt_d;
   logic [N-1:0]     corr_q, corr_d;
   logic             corr_chg_q, corr_chg_d;
   logic             stable_q, stable_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_LO;
         cnt_q       <= '0;
         humo_q      <= 1'b0;
         humo_rise_q <= 1'b0;
         cand_q      <= '0;
         ccnt_q      <= '0;
         corr_q      <= '0;
         corr_chg_q  <= 1'b0;
         stable_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         humo_q      <= humo_d;
         humo_rise_q <= humo_rise_d;
         cand_q      <= cand_d;
         ccnt_q      <= ccnt_d;
         corr_q      <= corr_d;
         corr_chg_q  <= corr_chg_d;
         stable_q    <= stable_d;
      end
   end

   // Humo debounce. The edge that enters WAIT_x counts as the first stable
   // sample; the level is accepted on the edge where cnt reaches DB_CYCLES-1,
   // so DB_CYCLES consecutive samples of the new level are required.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      humo_d      = humo_q;
      humo_rise_d = 1'b0;
      case (state_q)
         ST_LO: begin
            if (hs) begin
               state_d = ST_WAIT_HI;
               cnt_d   = '0;
            end
         end
         ST_WAIT_HI: begin
            if (!hs) begin
               state_d = ST_LO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d == LAST_CNT) begin
                  state_d     = ST_HI;
                  humo_d      = 1'b1;
                  humo_rise_d = 1'b1;
               end
            end
         end
         ST_HI: begin
            if (!hs) begin
               state_d = ST_WAIT_LO;
               cnt_d   = '0;
            end
         end
         ST_WAIT_LO: begin
            if (hs) begin
               state_d = ST_HI;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d == LAST_CNT) begin
                  state_d = ST_LO;
                  humo_d  = 1'b0;
               end
            end
         end
         default: state_d = ST_LO;
      endcase
   end

   // Current filter. A skewed multi-bit transition shows up as a candidate
   // that lives for one cycle and simply restarts the count.
   always_comb begin
      cand_d     = cand_q;
      ccnt_d     = ccnt_q;
      corr_d     = corr_q;
      corr_chg_d = 1'b0;
      if (cs != cand_q) begin
         cand_d = cs;
         ccnt_d = '0;
      end else begin
         if (ccnt_q != LAST_CNT) begin
            ccnt_d = ccnt_q + CNT_ONE;
         end
         // Once corriente takes cand the inequality clears, so the pulse
         // cannot repeat while the counter sits saturated.
         if ((ccnt_d == LAST_CNT) && (cand_q != corr_q)) begin
            corr_d     = cand_q;
            corr_chg_d = 1'b1;
         end
      end
   end

   // Registered so that it reads 0 while reset is held, like every other output.
   always_comb begin
      stable_d = is_settled(state_d) && (cand_d == corr_d);
   end

   assign humo      = humo_q;
   assign corriente = corr_q;
   assign humo_rise = humo_rise_q;
   assign corr_chg  = corr_chg_q;
   assign stable    = stable_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - randomized self-checking bench for sensor_conditioner
module tb_sensor_conditioner;

   localparam int N  = 3;
   localparam int DB = 4;
   localparam int CW = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         humo_in = 1'b0;
   logic [N-1:0] current_in = '0;
   logic         humo;
   logic [N-1:0] corriente;
   logic         humo_rise;
   logic         corr_chg;
   logic         stable;

   sensor_conditioner #(.N(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .humo_in    (humo_in),
      .current_in (current_in),
      .humo       (humo),
      .corriente  (corriente),
      .humo_rise  (humo_rise),
      .corr_chg   (corr_chg),
      .stable     (stable)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: inputs reach the filters two edges after being sampled;
   // an output takes value v once the last DB values seen are all v and differ
   // from the current output.
   bit           p1_h, p2_h;
   logic [N-1:0] p1_c, p2_c;
   bit           hwin[$];
   logic [N-1:0] cwin[$];
   bit           m_humo, m_rise, m_chg, m_stable;
   logic [N-1:0] m_corr;

   task automatic model_reset();
      p1_h = 0; p2_h = 0; p1_c = '0; p2_c = '0;
      hwin.delete(); cwin.delete();
      m_humo = 0; m_rise = 0; m_chg = 0; m_stable = 0; m_corr = '0;
   endtask

   task automatic model_edge(input bit h, input logic [N-1:0] c);
      bit           seen_h;
      logic [N-1:0] seen_c;
      bit           all_same;
      seen_h = p2_h; seen_c = p2_c;
      p2_h = p1_h;   p2_c = p1_c;
      p1_h = h;      p1_c = c;
      hwin.push_back(seen_h); if (hwin.size() > DB) void'(hwin.pop_front());
      cwin.push_back(seen_c); if (cwin.size() > DB) void'(cwin.pop_front());
      m_rise = 0; m_chg = 0;
      all_same = (hwin.size() == DB);
      foreach (hwin[i]) if (hwin[i] != seen_h) all_same = 0;
      if (all_same && seen_h != m_humo) begin
         m_humo = seen_h;
         m_rise = seen_h;
      end
      all_same = (cwin.size() == DB);
      foreach (cwin[i]) if (cwin[i] != seen_c) all_same = 0;
      if (all_same && seen_c != m_corr) begin
         m_corr = seen_c;
         m_chg  = 1;
      end
      m_stable = (seen_h == m_humo) && (seen_c == m_corr);
   endtask

   task automatic compare_all();
      check_eq("humo",      32'(humo),      32'(m_humo));
      check_eq("corriente", 32'(corriente), 32'(m_corr));
      check_eq("humo_rise", 32'(humo_rise), 32'(m_rise));
      check_eq("corr_chg",  32'(corr_chg),  32'(m_chg));
      check_eq("stable",    32'(stable),    32'(m_stable));
   endtask

   // One clock edge: advance the model with the inputs the DUT sampled, then
   // compare 1 ns later. Inputs are changed by the caller after return.
   task automatic tick();
      @(posedge clk);
      if (reset) model_edge(humo_in, current_in);
      else       model_reset();
      #1;
      compare_all();
   endtask

   initial begin
      model_reset();

      // 1: reset held, inputs toggling
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("rst_humo", 32'(humo), 32'd0);
         check_eq("rst_corr", 32'(corriente), 32'd0);
         humo_in    = $urandom_range(0, 1);
         current_in = N'($urandom_range(0, 7));
      end
      humo_in = 1'b0; current_in = '0;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();

      // 2: humo rises on edge 6 after first sampling
      humo_in = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_eq("t2_humo", 32'(humo), (i == 6) ? 32'd1 : 32'd0);
         check_eq("t2_rise", 32'(humo_rise), (i == 6) ? 32'd1 : 32'd0);
      end
      tick();
      check_eq("t2_rise_once", 32'(humo_rise), 32'd0);

      // 3: short glitch rejected
      humo_in = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check_eq("t3_pre_humo", 32'(humo), 32'd0);
      humo_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      humo_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("t3_humo", 32'(humo), 32'd0);
         check_eq("t3_rise", 32'(humo_rise), 32'd0);
      end
      check_eq("t3_stable", 32'(stable), 32'd1);

      // 4: current code accepted on edge 6
      current_in = 3'b101;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_eq("t4_corr", 32'(corriente), (i == 6) ? 32'd5 : 32'd0);
         check_eq("t4_chg", 32'(corr_chg), (i == 6) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t4_chg_once", 32'(corr_chg), 32'd0);
         check_eq("t4_stable", 32'(stable), 32'd1);
      end

      // 5: alternating code never qualifies
      for (int i = 1; i <= 40; i++) begin
         current_in = (((i - 1) / 2) % 2 == 0) ? 3'b010 : 3'b011;
         tick();
         check_eq("t5_corr", 32'(corriente), 32'd5);
         check_eq("t5_chg", 32'(corr_chg), 32'd0);
         if (i >= 3) check_eq("t5_stable", 32'(stable), 32'd0);
      end

      // 6: reset in WAIT_HI at cnt=2
      humo_in = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      humo_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      check_eq("t6_humo_now", 32'(humo), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_eq("t6_humo", 32'(humo), (i == 6) ? 32'd1 : 32'd0);
      end

      // Random phase, with occasional skewed current changes and resets
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            compare_all();
            tick();
            tick();
            reset = 1'b1;
         end
         if ($urandom_range(0, 5) == 0) humo_in = ~humo_in;
         case ($urandom_range(0, 11))
            0: current_in = N'($urandom_range(0, 7));
            1: current_in[$urandom_range(0, N - 1)] = ~current_in[$urandom_range(0, N - 1)];
            default: ;
         endcase
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
